// File: rtl/us_dist_filter_pkg.sv
// Shared definitions for the ultrasonic distance filter and its users.
// The default sizes are also used by the hcsr04 front ends.
package us_pkg;

  localparam int unsigned DefaultWidth       = 16;
  localparam int unsigned DefaultMaxCount    = 3800;
  localparam int unsigned DefaultRejectLimit = 3;
  localparam int unsigned HistDepth          = 4;

  typedef enum logic [1:0] {
    StScan    = 2'd0,
    StLoad    = 2'd1,
    StCompute = 2'd2,
    StWrite   = 2'd3
  } us_state_e;

endpackage

// File: rtl/us_dist_filter_avg4.sv
// Per-channel 4-entry distance history with primed flags.
// One shared adder tree produces the sum for the channel picked by sel.
module us_avg4
  import us_pkg::*;
#(
  parameter int unsigned NUM_CHANNELS = 9,
  parameter int unsigned WIDTH        = DefaultWidth,
  parameter int unsigned SEL_WIDTH    = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [SEL_WIDTH-1:0] sel,
  input  logic                 load,
  input  logic [WIDTH-1:0]     din,
  output logic                 primed,
  output logic [WIDTH+1:0]     sum
);

  logic [WIDTH-1:0]        hist_q [NUM_CHANNELS][HistDepth];
  logic [NUM_CHANNELS-1:0] primed_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      primed_q <= '0;
      for (int c = 0; c < NUM_CHANNELS; c++) begin
        for (int k = 0; k < HistDepth; k++) begin
          hist_q[c][k] <= '0;
        end
      end
    end else if (load) begin
      if (!primed_q[sel]) begin
        // First accepted sample seeds the whole window so the average starts at it.
        for (int k = 0; k < HistDepth; k++) begin
          hist_q[sel][k] <= din;
        end
        primed_q[sel] <= 1'b1;
      end else begin
        for (int k = 0; k < HistDepth - 1; k++) begin
          hist_q[sel][k] <= hist_q[sel][k+1];
        end
        hist_q[sel][HistDepth-1] <= din;
      end
    end
  end

  assign primed = primed_q[sel];

  always_comb begin
    sum = '0;
    for (int k = 0; k < HistDepth; k++) begin
      sum = sum + {2'b00, hist_q[sel][k]};
    end
  end

endmodule

// File: rtl/us_dist_filter.sv
// Multi-channel ultrasonic distance filter: edge capture, round-robin scanner,
// outlier rejection and 4-sample moving average per channel.
module us_dist_filter
  import us_pkg::*;
#(
  parameter int unsigned NUM_CHANNELS = 9,
  parameter int unsigned WIDTH        = DefaultWidth,
  parameter int unsigned MAX_COUNT    = DefaultMaxCount,
  parameter int unsigned REJECT_LIMIT = DefaultRejectLimit
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_CHANNELS*WIDTH-1:0] ticks_in,
  input  logic [NUM_CHANNELS-1:0]       valid_in,
  output logic [NUM_CHANNELS*WIDTH-1:0] dist_out,
  output logic [NUM_CHANNELS-1:0]       dist_valid,
  output logic [NUM_CHANNELS-1:0]       upd,
  output logic [NUM_CHANNELS-1:0]       overrun
);

  localparam int unsigned PtrW = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1;
  localparam int unsigned RejW = $clog2(REJECT_LIMIT + 1);

  localparam logic [WIDTH-1:0] MaxVal = WIDTH'(MAX_COUNT);
  localparam logic [RejW-1:0]  RejMax = RejW'(REJECT_LIMIT);
  localparam logic [PtrW-1:0]  LastCh = PtrW'(NUM_CHANNELS - 1);

  us_state_e               state_q;
  logic [PtrW-1:0]         ptr_q;
  logic [PtrW-1:0]         ptr_next;
  logic                    armed_q;
  logic [NUM_CHANNELS-1:0] valid_q;
  logic [NUM_CHANNELS-1:0] pending_q;
  logic [NUM_CHANNELS-1:0] pending_d;
  logic [NUM_CHANNELS-1:0] capture;
  logic [WIDTH-1:0]        sample_q [NUM_CHANNELS];
  logic [WIDTH-1:0]        work_q;
  logic [RejW-1:0]         rej_q [NUM_CHANNELS];
  logic [WIDTH-1:0]        dist_q [NUM_CHANNELS];

  logic             primed;
  logic [WIDTH+1:0] sum;
  logic [WIDTH-1:0] avg;
  logic [WIDTH-1:0] wr_val;
  logic             reject;
  logic             at_limit;
  logic             wr_en;
  logic             hist_load;

  // armed_q masks the first cycle after reset so a level already high is not an edge.
  assign capture  = armed_q ? (valid_in & ~valid_q) : '0;
  assign ptr_next = (ptr_q == LastCh) ? '0 : ptr_q + 1'b1;

  always_comb begin
    pending_d = pending_q;
    if (state_q == StLoad) begin
      pending_d[ptr_q] = 1'b0;
    end
    pending_d = pending_d | capture;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      armed_q   <= 1'b0;
      valid_q   <= '0;
      pending_q <= '0;
      overrun   <= '0;
      for (int i = 0; i < NUM_CHANNELS; i++) begin
        sample_q[i] <= '0;
      end
    end else begin
      armed_q   <= 1'b1;
      valid_q   <= valid_in;
      pending_q <= pending_d;
      overrun   <= overrun | (capture & pending_q);
      for (int i = 0; i < NUM_CHANNELS; i++) begin
        if (capture[i]) begin
          sample_q[i] <= ticks_in[WIDTH*i +: WIDTH];
        end
      end
    end
  end

  assign reject    = (work_q == '0) || (work_q >= MaxVal);
  assign hist_load = (state_q == StCompute) && !reject;
  assign avg       = WIDTH'(sum >> 2);
  assign at_limit  = (rej_q[ptr_q] == RejMax);
  assign wr_en     = at_limit || primed;
  assign wr_val    = at_limit ? MaxVal : avg;

  us_avg4 #(
    .NUM_CHANNELS(NUM_CHANNELS),
    .WIDTH       (WIDTH),
    .SEL_WIDTH   (PtrW)
  ) u_avg4 (
    .clk   (clk),
    .rst   (rst),
    .sel   (ptr_q),
    .load  (hist_load),
    .din   (work_q),
    .primed(primed),
    .sum   (sum)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StScan;
      ptr_q      <= '0;
      work_q     <= '0;
      dist_valid <= '0;
      upd        <= '0;
      for (int i = 0; i < NUM_CHANNELS; i++) begin
        rej_q[i]  <= '0;
        dist_q[i] <= '0;
      end
    end else begin
      upd <= '0;
      unique case (state_q)
        StScan: begin
          if (pending_q[ptr_q]) begin
            state_q <= StLoad;
          end else begin
            ptr_q <= ptr_next;
          end
        end
        StLoad: begin
          work_q  <= sample_q[ptr_q];
          state_q <= StCompute;
        end
        StCompute: begin
          if (!reject) begin
            rej_q[ptr_q] <= '0;
          end else if (rej_q[ptr_q] != RejMax) begin
            rej_q[ptr_q] <= rej_q[ptr_q] + 1'b1;
          end
          state_q <= StWrite;
        end
        StWrite: begin
          if (wr_en) begin
            dist_q[ptr_q]     <= wr_val;
            dist_valid[ptr_q] <= 1'b1;
            upd[ptr_q]        <= (wr_val != dist_q[ptr_q]);
          end
          ptr_q   <= ptr_next;
          state_q <= StScan;
        end
      endcase
    end
  end

  for (genvar g = 0; g < NUM_CHANNELS; g++) begin : g_dist
    assign dist_out[WIDTH*g +: WIDTH] = dist_q[g];
  end

endmodule
